// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared PE constants, instruction field layout and sequencer state type
package pe_pkg;
  localparam int INST_W    = 35;
  localparam int CTX_DEPTH = 16;

  localparam logic [INST_W-1:0] PE_NOP = '0;

  // Instruction packing, LSB first: reg_file_sel, 4x4 switch, 9x6 switch, fu_opcode
  localparam int REG_SEL_LSB = 0;
  localparam int REG_SEL_W   = 2;
  localparam int SW4X4_LSB   = 2;
  localparam int SW4X4_W     = 4;
  localparam int SW9X6_LSB   = 6;
  localparam int SW9X6_W     = 24;
  localparam int OPCODE_LSB  = 30;
  localparam int OPCODE_W    = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pe_ctx_state_t;
endpackage

// File: rtl/pe_ctx_mem.sv
// rtl/pe_ctx_mem.sv - context store: one synchronous write port, one combinational read port, no reset
module pe_ctx_mem
  import pe_pkg::*;
#(
  parameter int DEPTH  = CTX_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [INST_W-1:0] rdata_o
);
  logic [INST_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pe_ctx_seq.sv
// rtl/pe_ctx_seq.sv - per-PE context sequencer replaying stored instruction words into the PE
// Optional iteration counter enabled by defining PE_CTX_SEQ_ITER_EN.
module pe_ctx_seq
  import pe_pkg::*;
#(
  parameter int DEPTH  = CTX_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [INST_W-1:0] cfg_data,
  input  logic              start,
  input  logic [ADDR_W:0]   ctx_len,
  input  logic [ITER_W-1:0] iter_cnt,
  input  logic              stall,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] ctx_idx,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

  pe_ctx_state_t     state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   eff_len;
  logic [ITER_W-1:0] eff_iter;
  logic [INST_W-1:0] rd_data;
  logic              mem_we;

  assign eff_len = (ctx_len > DEPTH_L) ? DEPTH_L : ctx_len;

`ifdef PE_CTX_SEQ_ITER_EN
  assign eff_iter = (iter_cnt == '0) ? ITER_ONE : iter_cnt;
`else
  logic unused_iter_cnt;
  assign unused_iter_cnt = ^iter_cnt;
  assign eff_iter        = ITER_ONE;
`endif

  assign mem_we = cfg_valid && (state_q == IDLE);

  pe_ctx_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .raddr_i (pc_q),
    .rdata_o (rd_data)
  );

  // iter_q counts remaining passes; reaching zero in RUN marks the completion cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    iter_d  = iter_q;
    inst_d  = PE_NOP;
    idx_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cfg_valid && (eff_len != '0)) begin
          state_d = RUN;
          pc_d    = '0;
          len_d   = eff_len;
          iter_d  = eff_iter;
        end
      end
      RUN: begin
        if (iter_q == '0) begin
          state_d = IDLE;
          pc_d    = '0;
          done_d  = 1'b1;
        end else if (!stall) begin
          inst_d = rd_data;
          idx_d  = pc_q;
          if ({1'b0, pc_q} == (len_q - LEN_ONE)) begin
            pc_d   = '0;
            iter_d = iter_q - ITER_ONE;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      iter_q  <= '0;
      inst_q  <= PE_NOP;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      iter_q  <= iter_d;
      inst_q  <= inst_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign inst      = inst_q;
  assign ctx_idx   = idx_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);
  assign cfg_ready = (state_q == IDLE);
endmodule

// File: doc/pe_ctx_seq.md
# pe_ctx_seq

Per-PE context sequencer that stores a small program of PE instruction words and issues one 35-bit word per cycle to the PE's `inst` input. It sits directly upstream of the processing element. It is loaded over a valid/ready configuration port while idle, then replays contexts `0..len-1` for a programmed number of iterations. Stall cycles are filled with NOP words, and `done` is pulsed when the run completes.

## Interface
- `INST_W`, 35, instruction word width (fu_opcode / 9x6 switch / 4x4 switch / reg_file_sel packing)
- `DEPTH`, 16, number of context entries
- `ADDR_W`, 4, log2(DEPTH)
- `ITER_W`, 16, iteration counter width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high; clock `clk`
- `cfg_valid`  in  1  context write request
- `cfg_ready`  out  1  high when a write can be accepted (state IDLE)
- `cfg_addr`  in  ADDR_W  context index to write
- `cfg_data`  in  INST_W  instruction word to store
- `start`  in  1  begin run (sampled in IDLE only)
- `ctx_len`  in  ADDR_W+1  contexts per iteration, latched at start
- `iter_cnt`  in  ITER_W  iterations, latched at start
- `stall`  in  1  hold program position, issue NOP
- `inst`  out  INST_W  registered instruction to PE
- `ctx_idx`  out  ADDR_W  index of the context currently on `inst` (0 when NOP)
- `busy`  out  1  state == RUN
- `done`  out  1  one-cycle pulse at run completion

## Operation
- NOP is defined as all-zero `INST_W`.
- States: IDLE, RUN.
- IDLE:
  - `cfg_ready`=1.
  - `cfg_valid` writes `cfg_data` to `mem[cfg_addr]` at the clock edge.
  - `inst`=NOP.
- IDLE→RUN when `start`=1 and `cfg_valid`=0 and the effective length is nonzero.
  - Effective length: `ctx_len` clamped to DEPTH.
  - Effective iterations: `iter_cnt`, with 0 treated as 1.
  - `start` with effective length 0 is ignored.
  - `start` in the same cycle as `cfg_valid` is ignored; the write is still performed.
- RUN:
  - `cfg_ready`=0; `cfg_valid` has no effect.
  - Each non-stalled cycle registers `inst <= mem[pc]`, `ctx_idx <= pc`, then advances `pc`.
  - `pc` wraps to 0 after `len-1` and decrements the remaining-iteration counter.
  - `stall`=1: `inst <= NOP`; `pc` and the iteration counter hold.
  - `start` in RUN is ignored.
- RUN→IDLE: in the cycle after the final context of the final iteration is issued, `inst <= NOP` and `done <= 1` for exactly one cycle.
  - `stall` during that completion cycle has no effect.
- Context memory is not cleared by `rst`. Contents persist across runs and resets.

## Timing
- Reset values: `inst`=NOP, `ctx_idx`=0, `busy`=0, `done`=0, `cfg_ready`=1, state IDLE, `pc`=0.
- `start` sampled at edge T → `inst`=`mem[0]` and `busy`=1 after edge T+1.
- With no stalls, context k of iteration i appears after edge T+1+i·len+k.
- `done`=1 and `busy`=0 after edge T+len·iter+1 + (number of stall cycles).
- `cfg_ready` returns to 1 in the same cycle as `done`. A new `start` is accepted that cycle.
- Stall-to-output latency is 1 cycle: `stall` sampled at edge E → NOP after E.
- `rst` mid-run: after the reset edge, outputs return to reset values; no `done` pulse.
- Write is synchronous; data written at edge W is readable by a run started at or after W.

## Configuration
- `PE_CTX_SEQ_ITER_EN` defined:
  - iteration counter present; `iter_cnt` honoured as above.
- Not defined:
  - `iter_cnt` is ignored (port retained, unused) and every run is a single pass of `len` contexts.
  - `done` follows at T+len+1+stalls.

## Structure
- Shared package `pe_pkg`: `INST_W`, `PE_NOP` constant, instruction field offsets (opcode, switch_9x6, switch_4x4, reg_file_sel), and the `pe_ctx_state_t` enum {IDLE, RUN}.
- One sub-module, `pe_ctx_mem`:
  - DEPTH×INST_W array, one sync write port, one combinational read port.
  - No reset.
- The control FSM, counters and output register live in `pe_ctx_seq`.

## Test plan
- Load `mem[0..2]`=`35'h1`, `35'h2`, `35'h3`; start with `ctx_len`=3, `iter_cnt`=2 → `inst` sequence 1,2,3,1,2,3,NOP; `done` high one cycle, 7 cycles after start.
- Same program, `stall` high for 2 cycles while `ctx_idx`=1 → sequence 1,2,NOP,NOP,3,1,2,3,NOP; `done` delayed by 2 cycles.
- `ctx_len`=0 with `start` → stays IDLE, `busy`=0, no `done`. `ctx_len`=20 → clamps to 16 and issues `ctx_idx` 0..15.
- `cfg_valid` and `start` in the same cycle → write to `mem[5]` lands, no run. Writes attempted during RUN (`cfg_ready`=0) → `mem` unchanged.
- `rst` asserted at the 3rd issued context → `inst`=NOP, `busy`=0, no `done`. A rerun without reload replays the original contents.
- With `PE_CTX_SEQ_ITER_EN` undefined: `iter_cnt`=5, `ctx_len`=2 → exactly 2 contexts issued, then `done`.
